ssd1306_spi_rx: RTL and testbench

SSD1306_SPI_RX -- requirements
Module: ssd1306_spi_rx

---
 rtl/ssd1306_pkg.sv | 43 ++++
 rtl/ssd1306_spi_rx_if.sv | 15 +
 rtl/ssd1306_spi_byte_rx.sv | 104 ++++++++++
 rtl/ssd1306_spi_rx.sv | 194 +++++++++++++++++++
 tb/tb_ssd1306_spi_rx.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg -- shared definitions for the SSD1306-style SPI command receiver.
// Contents: opcode constants (same values as the panel controller command set),
// register reset defaults, decoder FSM state type and memory addressing modes.
package ssd1306_pkg;

  // Single-byte opcodes
  localparam logic [7:0] OP_DISP_OFF  = 8'hAE;
  localparam logic [7:0] OP_DISP_ON   = 8'hAF;
  localparam logic [7:0] OP_INV_OFF   = 8'hA6;
  localparam logic [7:0] OP_INV_ON    = 8'hA7;
  localparam logic [7:0] OP_SET_PAGE  = 8'hB0;  // B0..B7, low 3 bits = page
  localparam logic [7:0] OP_COL_LO    = 8'h00;  // 00..0F, low nibble = col[3:0]
  localparam logic [7:0] OP_COL_HI    = 8'h10;  // 10..17, low 3 bits = col[6:4]

  // Opcodes taking arguments
  localparam logic [7:0] OP_CONTRAST  = 8'h81;
  localparam logic [7:0] OP_CHG_PUMP  = 8'h8D;
  localparam logic [7:0] OP_MEM_MODE  = 8'h20;
  localparam logic [7:0] OP_MUX       = 8'hA8;
  localparam logic [7:0] OP_COL_ADDR  = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR = 8'h22;

  // Register defaults
  localparam logic [7:0] DEF_CONTRAST = 8'h7F;
  localparam logic [5:0] DEF_MUX      = 6'd63;
  localparam logic [5:0] MUX_MIN      = 6'd15;
  localparam logic [6:0] COL_LAST     = 7'd127;
  localparam logic [2:0] PAGE_LAST    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG1 = 2'd1,
    ST_ARG2 = 2'd2
  } dec_state_e;

  typedef enum logic [1:0] {
    MEM_HORZ = 2'b00,
    MEM_VERT = 2'b01,
    MEM_PAGE = 2'b10,
    MEM_BAD  = 2'b11
  } mem_mode_e;

endpackage

// File: rtl/ssd1306_spi_rx_if.sv
// ssd1306_spi_rx_if -- host-to-panel pin bundle.
// spi_sclk/spi_mosi/spi_ss : SPI mode 0, MSB first, ss active-low
// oled_dc                  : 1 = data byte, 0 = command byte
// oled_res                 : active-low panel reset
// master = host driving the pins, slave = receiver.
interface ssd1306_spi_rx_if;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_ss;
  logic oled_dc;
  logic oled_res;

  modport master (output spi_sclk, output spi_mosi, output spi_ss, output oled_dc, output oled_res);
  modport slave  (input  spi_sclk, input  spi_mosi, input  spi_ss, input  oled_dc, input  oled_res);
endinterface

// File: rtl/ssd1306_spi_byte_rx.sv
// ssd1306_spi_byte_rx -- synchronizes the SPI/panel pins and assembles bytes.
// Ports: clk_50M, rst_n (async, active-low); spi (slave pin bundle);
//        res_n_o        synchronized oled_res (low = hold defaults)
//        byte_valid_o   one-cycle pulse, one clock after the 8th sclk rise
//        byte_data_o    received byte, MSB first
//        byte_is_data_o oled_dc as sampled at the 8th sclk rise
module ssd1306_spi_byte_rx #(
  parameter int SCLK_MAX_DIV = 8
) (
  input  logic                   clk_50M,
  input  logic                   rst_n,
  ssd1306_spi_rx_if.slave        spi,
  output logic                   res_n_o,
  output logic                   byte_valid_o,
  output logic [7:0]             byte_data_o,
  output logic                   byte_is_data_o
);

  // Bit order in the sync chain: {res, dc, ss, mosi, sclk}; ss idles high.
  localparam logic [4:0] SYNC_RST = 5'b00100;
  // After an accepted rise, further rises are ignored for half a minimum
  // sclk period; this rejects bounce without touching legitimate edges.
  localparam logic [7:0] HOLDOFF = 8'(SCLK_MAX_DIV / 2);

  logic [4:0] sync1_q, sync2_q;
  logic       sclk_prev_q;
  logic [7:0] holdoff_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       byte_valid_q;
  logic [7:0] byte_data_q;
  logic       byte_is_data_q;

  logic sclk_s, mosi_s, ss_s, dc_s, res_n_s, rise_s;

  assign sclk_s  = sync2_q[0];
  assign mosi_s  = sync2_q[1];
  assign ss_s    = sync2_q[2];
  assign dc_s    = sync2_q[3];
  assign res_n_s = sync2_q[4];

  // Accepted sclk rising edge on the synchronized clock
  always_comb begin
    rise_s = sclk_s & ~sclk_prev_q & (holdoff_q == 8'd0);
  end

  // Two-flop synchronizers for every asynchronous pin
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
    end else begin
      sync1_q <= {spi.oled_res, spi.oled_dc, spi.spi_ss, spi.spi_mosi, spi.spi_sclk};
      sync2_q <= sync1_q;
    end
  end

  // Edge detect, shift register, bit counter and byte strobe
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_q    <= 1'b0;
      holdoff_q      <= 8'd0;
      bit_cnt_q      <= 3'd0;
      shift_q        <= 8'd0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= 8'd0;
      byte_is_data_q <= 1'b0;
    end else if (!res_n_s) begin
      // Panel reset: drop any byte in flight; keep tracking sclk so that
      // release does not produce a false edge.
      sclk_prev_q    <= sclk_s;
      holdoff_q      <= 8'd0;
      bit_cnt_q      <= 3'd0;
      shift_q        <= 8'd0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= 8'd0;
      byte_is_data_q <= 1'b0;
    end else begin
      sclk_prev_q  <= sclk_s;
      byte_valid_q <= 1'b0;
      if (holdoff_q != 8'd0) begin
        holdoff_q <= holdoff_q - 8'd1;
      end
      if (ss_s) begin
        bit_cnt_q <= 3'd0;  // deselect discards a partial byte
      end else if (rise_s) begin
        holdoff_q <= HOLDOFF;
        shift_q   <= {shift_q[6:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_valid_q   <= 1'b1;
          byte_data_q    <= {shift_q[6:0], mosi_s};
          byte_is_data_q <= dc_s;
        end
      end
    end
  end

  assign res_n_o        = res_n_s;
  assign byte_valid_o   = byte_valid_q;
  assign byte_data_o    = byte_data_q;
  assign byte_is_data_o = byte_is_data_q;

endmodule

// File: rtl/ssd1306_spi_rx.sv
// ssd1306_spi_rx -- SPI receiver, command decoder and GDDRAM address generator.
// Ports: clk_50M, rst_n (async, active-low); spi (slave pin bundle);
//   byte_valid/byte_data/byte_is_data : received byte strobe
//   display_on, contrast, invert, mux_ratio, charge_pump, mem_mode : panel registers
//   ram_we/ram_addr {page,col}/ram_wdata : display RAM write port
//   cmd_err : one-cycle pulse on unknown opcode, bad argument or aborted command
module ssd1306_spi_rx
  import ssd1306_pkg::*;
#(
  parameter int SCLK_MAX_DIV = 8
) (
  input  logic            clk_50M,
  input  logic            rst_n,
  ssd1306_spi_rx_if.slave spi,
  output logic            byte_valid,
  output logic [7:0]      byte_data,
  output logic            byte_is_data,
  output logic            display_on,
  output logic [7:0]      contrast,
  output logic            invert,
  output logic [5:0]      mux_ratio,
  output logic            charge_pump,
  output logic [1:0]      mem_mode,
  output logic            ram_we,
  output logic [9:0]      ram_addr,
  output logic [7:0]      ram_wdata,
  output logic            cmd_err
);

  logic       res_n_s, rx_valid_s, rx_is_data_s;
  logic [7:0] rx_data_s;

  ssd1306_spi_byte_rx #(.SCLK_MAX_DIV(SCLK_MAX_DIV)) u_byte_rx (
    .clk_50M        (clk_50M),
    .rst_n          (rst_n),
    .spi            (spi),
    .res_n_o        (res_n_s),
    .byte_valid_o   (rx_valid_s),
    .byte_data_o    (rx_data_s),
    .byte_is_data_o (rx_is_data_s)
  );

  dec_state_e state_q;
  mem_mode_e  mem_mode_q;
  logic [7:0] op_q, contrast_q, ram_wdata_q;
  logic [6:0] arg1_q, col_q, col_start_q, col_end_q, col_d;
  logic [2:0] page_q, page_start_q, page_end_q, page_d;
  logic [5:0] mux_ratio_q;
  logic [9:0] ram_addr_q;
  logic       display_on_q, invert_q, charge_pump_q, ram_we_q, cmd_err_q;
  logic       is_page_s, is_col_lo_s, is_col_hi_s;

  assign is_page_s   = (rx_data_s[7:3] == OP_SET_PAGE[7:3]);
  assign is_col_lo_s = (rx_data_s[7:4] == OP_COL_LO[7:4]);
  assign is_col_hi_s = (rx_data_s[7:3] == OP_COL_HI[7:3]);

  // Address that follows the current one, per addressing mode
  always_comb begin
    col_d  = col_q;
    page_d = page_q;
    case (mem_mode_q)
      MEM_HORZ: begin
        if (col_q == col_end_q) begin
          col_d  = col_start_q;
          page_d = (page_q == page_end_q) ? page_start_q : page_q + 3'd1;
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      MEM_VERT: begin
        if (page_q == page_end_q) begin
          page_d = page_start_q;
          col_d  = (col_q == col_end_q) ? col_start_q : col_q + 7'd1;
        end else begin
          page_d = page_q + 3'd1;
        end
      end
      MEM_PAGE: col_d = col_q + 7'd1;  // 127 wraps to 0 naturally
      default:  col_d = col_q;
    endcase
  end

  // Decoder FSM, panel registers and RAM write port
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;       op_q <= 8'd0;            arg1_q <= 7'd0;
      display_on_q <= 1'b0;     contrast_q <= DEF_CONTRAST; invert_q <= 1'b0;
      mux_ratio_q <= DEF_MUX;   charge_pump_q <= 1'b0;   mem_mode_q <= MEM_PAGE;
      col_q <= 7'd0;            col_start_q <= 7'd0;     col_end_q <= COL_LAST;
      page_q <= 3'd0;           page_start_q <= 3'd0;    page_end_q <= PAGE_LAST;
      ram_we_q <= 1'b0;         ram_addr_q <= 10'd0;     ram_wdata_q <= 8'd0;
      cmd_err_q <= 1'b0;
    end else if (!res_n_s) begin
      state_q <= ST_IDLE;       op_q <= 8'd0;            arg1_q <= 7'd0;
      display_on_q <= 1'b0;     contrast_q <= DEF_CONTRAST; invert_q <= 1'b0;
      mux_ratio_q <= DEF_MUX;   charge_pump_q <= 1'b0;   mem_mode_q <= MEM_PAGE;
      col_q <= 7'd0;            col_start_q <= 7'd0;     col_end_q <= COL_LAST;
      page_q <= 3'd0;           page_start_q <= 3'd0;    page_end_q <= PAGE_LAST;
      ram_we_q <= 1'b0;         ram_addr_q <= 10'd0;     ram_wdata_q <= 8'd0;
      cmd_err_q <= 1'b0;
    end else begin
      ram_we_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
      // ram_addr follows the current pointer; on a write it still shows the
      // written address because the pointer advances on the same edge.
      ram_addr_q <= {page_q, col_q};
      if (rx_valid_s && rx_is_data_s) begin
        ram_we_q    <= 1'b1;
        ram_wdata_q <= rx_data_s;
        col_q       <= col_d;
        page_q      <= page_d;
        if (state_q != ST_IDLE) begin
          cmd_err_q <= 1'b1;  // data cut into an unfinished command
          state_q   <= ST_IDLE;
        end
      end else if (rx_valid_s) begin
        case (state_q)
          ST_IDLE: begin
            if (is_page_s) begin
              page_q <= rx_data_s[2:0];
            end else if (is_col_lo_s) begin
              col_q[3:0] <= rx_data_s[3:0];
            end else if (is_col_hi_s) begin
              col_q[6:4] <= rx_data_s[2:0];
            end else begin
              case (rx_data_s)
                OP_DISP_OFF, OP_DISP_ON: display_on_q <= rx_data_s[0];
                OP_INV_OFF, OP_INV_ON:   invert_q <= rx_data_s[0];
                OP_CONTRAST, OP_CHG_PUMP, OP_MEM_MODE, OP_MUX,
                OP_COL_ADDR, OP_PAGE_ADDR: begin
                  op_q    <= rx_data_s;
                  state_q <= ST_ARG1;
                end
                default: cmd_err_q <= 1'b1;
              endcase
            end
          end
          ST_ARG1: begin
            state_q <= ST_IDLE;
            arg1_q  <= rx_data_s[6:0];
            case (op_q)
              OP_CONTRAST: contrast_q <= rx_data_s;
              OP_CHG_PUMP: charge_pump_q <= rx_data_s[2];
              OP_MEM_MODE: begin
                if (rx_data_s[1:0] == MEM_BAD) cmd_err_q <= 1'b1;
                else mem_mode_q <= mem_mode_e'(rx_data_s[1:0]);
              end
              OP_MUX: begin
                if (rx_data_s[5:0] < MUX_MIN) cmd_err_q <= 1'b1;
                else mux_ratio_q <= rx_data_s[5:0];
              end
              OP_COL_ADDR, OP_PAGE_ADDR: state_q <= ST_ARG2;
              default: cmd_err_q <= 1'b1;
            endcase
          end
          ST_ARG2: begin
            state_q <= ST_IDLE;
            case (op_q)
              OP_COL_ADDR: begin
                col_start_q <= arg1_q;
                col_end_q   <= rx_data_s[6:0];
                col_q       <= arg1_q;
              end
              OP_PAGE_ADDR: begin
                page_start_q <= arg1_q[2:0];
                page_end_q   <= rx_data_s[2:0];
                page_q       <= arg1_q[2:0];
              end
              default: cmd_err_q <= 1'b1;
            endcase
          end
          default: state_q <= ST_IDLE;
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign byte_valid   = rx_valid_s;
  assign byte_data    = rx_data_s;
  assign byte_is_data = rx_is_data_s;
  assign display_on   = display_on_q;
  assign contrast     = contrast_q;
  assign invert       = invert_q;
  assign mux_ratio    = mux_ratio_q;
  assign charge_pump  = charge_pump_q;
  assign mem_mode     = mem_mode_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign cmd_err      = cmd_err_q;

endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// tb_ssd1306_spi_rx -- directed scoreboard bench for ssd1306_spi_rx.
// Stimulus pushes expected bytes and RAM writes into queues; a negedge
// monitor pops and compares whenever the DUT pulses byte_valid or ram_we.
module tb_ssd1306_spi_rx;

  localparam int HALF = 10;  // clk cycles per sclk half period

  logic clk_50M = 1'b0;
  logic rst_n;
  logic       byte_valid, byte_is_data, display_on, invert, charge_pump;
  logic       ram_we, cmd_err;
  logic [7:0] byte_data, contrast, ram_wdata;
  logic [5:0] mux_ratio;
  logic [1:0] mem_mode;
  logic [9:0] ram_addr;

  always #10 clk_50M = ~clk_50M;

  ssd1306_spi_rx_if bus ();

  ssd1306_spi_rx #(.SCLK_MAX_DIV(8)) dut (
    .clk_50M      (clk_50M),
    .rst_n        (rst_n),
    .spi          (bus.slave),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .display_on   (display_on),
    .contrast     (contrast),
    .invert       (invert),
    .mux_ratio    (mux_ratio),
    .charge_pump  (charge_pump),
    .mem_mode     (mem_mode),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .cmd_err      (cmd_err)
  );

  logic [8:0]  exp_byte_q[$];  // {is_data, data}
  logic [17:0] exp_ram_q[$];   // {addr, wdata}
  logic [8:0]  mon_b;
  logic [17:0] mon_r;
  int n_assert = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int err_exp  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk_50M) begin
    if (byte_valid === 1'b1) begin
      if (exp_byte_q.size() == 0) begin
        n_assert++; n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h, expected none", byte_data);
      end else begin
        mon_b = exp_byte_q.pop_front();
        check("byte_rx", {23'd0, byte_is_data, byte_data}, {23'd0, mon_b});
      end
    end
    if (ram_we === 1'b1) begin
      if (exp_ram_q.size() == 0) begin
        n_assert++; n_fail++;
        $display("FAIL unexpected_ram_we: got addr 0x%0h data 0x%0h, expected none", ram_addr, ram_wdata);
      end else begin
        mon_r = exp_ram_q.pop_front();
        check("ram_write", {14'd0, ram_addr, ram_wdata}, {14'd0, mon_r});
      end
    end
    if (cmd_err === 1'b1) err_seen++;
  end

  task automatic spi_bits(input logic [7:0] b, input int nbits, input logic dc);
    bus.oled_dc = dc;
    bus.spi_ss  = 1'b0;
    repeat (HALF) @(negedge clk_50M);
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_mosi = b[i];
      repeat (HALF) @(negedge clk_50M);
      bus.spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk_50M);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic dc);
    exp_byte_q.push_back({dc, b});
    spi_bits(b, 8, dc);
    repeat (HALF) @(negedge clk_50M);
    bus.spi_ss = 1'b1;
    repeat (HALF) @(negedge clk_50M);
  endtask

  task automatic cmd(input logic [7:0] b);
    send(b, 1'b0);
  endtask

  task automatic dat(input logic [7:0] b, input logic [9:0] addr);
    exp_ram_q.push_back({addr, b});
    send(b, 1'b1);
  endtask

  task automatic check_defaults(input string tag);
    check({tag, ".display_on"},  {31'd0, display_on},  32'h0);
    check({tag, ".contrast"},    {24'd0, contrast},    32'h7F);
    check({tag, ".invert"},      {31'd0, invert},      32'h0);
    check({tag, ".mux_ratio"},   {26'd0, mux_ratio},   32'd63);
    check({tag, ".charge_pump"}, {31'd0, charge_pump}, 32'h0);
    check({tag, ".mem_mode"},    {30'd0, mem_mode},    32'h2);
    check({tag, ".ram_addr"},    {22'd0, ram_addr},    32'h0);
    check({tag, ".ram_we"},      {31'd0, ram_we},      32'h0);
    check({tag, ".cmd_err"},     {31'd0, cmd_err},     32'h0);
    check({tag, ".byte_valid"},  {31'd0, byte_valid},  32'h0);
  endtask

  initial begin
    bus.spi_sclk = 1'b0; bus.spi_mosi = 1'b0; bus.spi_ss = 1'b1;
    bus.oled_dc = 1'b0;  bus.oled_res = 1'b1; rst_n = 1'b0;
    repeat (5) @(negedge clk_50M);
    check_defaults("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50M);

    // Data byte aborts a pending 0x81; mux argument below 15 rejected
    cmd(8'h81); dat(8'h55, 10'h000); err_exp++;
    check("abort.cmd_err", err_seen, err_exp);
    check("abort.contrast", {24'd0, contrast}, 32'h7F);
    cmd(8'hA8); cmd(8'h0A); err_exp++;
    check("mux_reject.cmd_err", err_seen, err_exp);
    check("mux_reject.mux_ratio", {26'd0, mux_ratio}, 32'd63);
    cmd(8'hA8); cmd(8'h0F);
    check("mux_min.mux_ratio", {26'd0, mux_ratio}, 32'd15);

    // Basic decode with no errors
    cmd(8'hAF); cmd(8'h81); cmd(8'h3C); cmd(8'hA7);
    check("decode.display_on", {31'd0, display_on}, 32'h1);
    check("decode.contrast", {24'd0, contrast}, 32'h3C);
    check("decode.invert", {31'd0, invert}, 32'h1);
    check("decode.cmd_err", err_seen, err_exp);

    // Partial byte discarded on ss rise
    cmd(8'hAE);
    check("partial.display_off", {31'd0, display_on}, 32'h0);
    spi_bits(8'hA0, 5, 1'b0);
    bus.spi_ss = 1'b1;
    repeat (HALF) @(negedge clk_50M);
    cmd(8'hAF);
    check("partial.display_on", {31'd0, display_on}, 32'h1);

    // Page mode wrap at column 127
    cmd(8'hB3); cmd(8'h0F); cmd(8'h17);
    check("page.addr_set", {22'd0, ram_addr}, 32'h1FF);
    dat(8'h11, 10'h1FF); dat(8'h22, 10'h180);
    check("page.addr_after", {22'd0, ram_addr}, 32'h181);

    // Horizontal mode window wrap
    cmd(8'h20); cmd(8'h00);
    check("horz.mem_mode", {30'd0, mem_mode}, 32'h0);
    cmd(8'h21); cmd(8'h7E); cmd(8'h7F);
    cmd(8'h22); cmd(8'h06); cmd(8'h07);
    dat(8'hD0, 10'h37E); dat(8'hD1, 10'h37F); dat(8'hD2, 10'h3FE);
    dat(8'hD3, 10'h3FF); dat(8'hD4, 10'h37E);

    // Bad mem_mode, unknown opcode, charge pump
    cmd(8'h20); cmd(8'h03); err_exp++;
    check("bad_mode.cmd_err", err_seen, err_exp);
    check("bad_mode.mem_mode", {30'd0, mem_mode}, 32'h0);
    cmd(8'hFF); err_exp++;
    check("unknown.cmd_err", err_seen, err_exp);
    cmd(8'h8D); cmd(8'h14);
    check("chg_pump", {31'd0, charge_pump}, 32'h1);

    // Vertical mode wrap
    cmd(8'h20); cmd(8'h01);
    dat(8'hE0, 10'h37F); dat(8'hE1, 10'h3FF);
    check("vert.addr_after", {22'd0, ram_addr}, 32'h37E);

    // Asynchronous reset mid-byte
    cmd(8'hAF); cmd(8'h81); cmd(8'h20);
    check("pre_rst.contrast", {24'd0, contrast}, 32'h20);
    spi_bits(8'hC3, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    check_defaults("async_rst");
    bus.spi_ss = 1'b1;
    @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50M);

    // Panel reset mid-byte; ss stays low across it
    cmd(8'hAF); cmd(8'h81); cmd(8'h20);
    spi_bits(8'hC3, 3, 1'b0);
    bus.oled_res = 1'b0;
    repeat (4) @(negedge clk_50M);
    check_defaults("oled_res");
    bus.oled_res = 1'b1;
    repeat (4) @(negedge clk_50M);
    cmd(8'hAF);
    check("post_res.display_on", {31'd0, display_on}, 32'h1);

    repeat (5) @(negedge clk_50M);
    check("end.bytes_left", exp_byte_q.size(), 32'd0);
    check("end.ram_left", exp_ram_q.size(), 32'd0);
    check("end.cmd_err_count", err_seen, err_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
